// File: rtl/pipe_exe_emreg.sv
// Execute stage (operand select, ALU, jal link) feeding the EX/MEM pipeline register.
// Define PIPE_EXE_MUL_EN to add an iterative shift-add multiplier for ealuc=1011.
module pipe_exe_emreg #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ebubble,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic             ewmem,
    input  logic [3:0]       ealuc,
    input  logic             ealuimm,
    input  logic             eshift,
    input  logic             ejal,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic [WIDTH-1:0] eimm,
    input  logic [WIDTH-1:0] esa,
    input  logic [WIDTH-1:0] epc4,
    input  logic [4:0]       ern0,
    output logic [4:0]       ern,
    output logic             ex_stall,
    output logic             mwreg,
    output logic             mm2reg,
    output logic             mwmem,
    output logic [WIDTH-1:0] malu,
    output logic [WIDTH-1:0] mb,
    output logic [4:0]       mrn
);

    localparam logic [3:0] ALUC_MUL = 4'b1011;

    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic [WIDTH-1:0] alu_s;
    logic [WIDTH-1:0] result_s;
    logic [WIDTH-1:0] mul_result_s;
    logic             ex_stall_s;

    assign op_a_s   = eshift ? esa : ea;
    assign op_b_s   = ealuimm ? eimm : eb;
    assign result_s = ejal ? (epc4 + 32'd4) : alu_s;
    assign ern      = ejal ? 5'd31 : ern0;
    assign ex_stall = ex_stall_s;

`ifdef PIPE_EXE_MUL_EN
    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    mul_state_e       mul_state_r;
    mul_state_e       mul_state_s;
    logic             mul_start_s;
    logic [4:0]       count_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] prod_r;

    // Multiplier next-state, start pulse and stall request.
    always_comb begin
        mul_state_s = mul_state_r;
        mul_start_s = 1'b0;
        case (mul_state_r)
            MUL_IDLE: begin
                if ((ealuc == ALUC_MUL) && !ebubble) begin
                    mul_start_s = 1'b1;
                    mul_state_s = MUL_BUSY;
                end else begin
                    mul_state_s = MUL_IDLE;
                end
            end
            MUL_BUSY: begin
                if (count_r == 5'd31) begin
                    mul_state_s = MUL_DONE;
                end else begin
                    mul_state_s = MUL_BUSY;
                end
            end
            MUL_DONE: mul_state_s = MUL_IDLE;
            default:  mul_state_s = MUL_IDLE;
        endcase
        // Stall is masked during reset so the hazard unit never sees a stale request.
        ex_stall_s   = resetn & ~ebubble & (mul_start_s | (mul_state_r == MUL_BUSY));
        mul_result_s = (mul_state_r == MUL_DONE) ? prod_r : 32'd0;
    end

    // Multiplier state and shift-add datapath, one multiplier bit per cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            mul_state_r <= MUL_IDLE;
            count_r     <= 5'd0;
            mcand_r     <= 32'd0;
            mplier_r    <= 32'd0;
            prod_r      <= 32'd0;
        end else begin
            mul_state_r <= mul_state_s;
            if (mul_start_s) begin
                mcand_r  <= op_a_s;
                mplier_r <= op_b_s;
                prod_r   <= 32'd0;
                count_r  <= 5'd0;
            end else if (mul_state_r == MUL_BUSY) begin
                if (mplier_r[0]) begin
                    prod_r <= prod_r + mcand_r;
                end else begin
                    prod_r <= prod_r;
                end
                mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
                mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                count_r  <= count_r + 5'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end
`else
    // No multiplier: MUL decodes to zero and the stage never stalls.
    always_comb begin
        ex_stall_s   = 1'b0;
        mul_result_s = 32'd0;
    end
`endif

    // ALU function select; bit 3 only matters for the shift/multiply group.
    always_comb begin
        alu_s = 32'd0;
        casez (ealuc)
            4'b?000: alu_s = op_a_s + op_b_s;
            4'b?100: alu_s = op_a_s - op_b_s;
            4'b?001: alu_s = op_a_s & op_b_s;
            4'b?101: alu_s = op_a_s | op_b_s;
            4'b?010: alu_s = op_a_s ^ op_b_s;
            4'b?110: alu_s = {op_b_s[15:0], 16'h0000};
            4'b0011: alu_s = op_b_s << op_a_s[4:0];
            4'b0111: alu_s = op_b_s >> op_a_s[4:0];
            4'b1111: alu_s = $signed(op_b_s) >>> op_a_s[4:0];
            4'b1011: alu_s = mul_result_s;
            default: alu_s = 32'd0;
        endcase
    end

    // EX/MEM register; a stall injects a bubble into M and holds the data fields.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
            malu   <= 32'd0;
            mb     <= 32'd0;
            mrn    <= 5'd0;
        end else if (ex_stall_s) begin
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
        end else begin
            mwreg  <= ewreg  & ~ebubble;
            mm2reg <= em2reg & ~ebubble;
            mwmem  <= ewmem  & ~ebubble;
            malu   <= result_s;
            mb     <= eb;
            mrn    <= ern;
        end
    end

endmodule

// File: tb/tb_pipe_exe_emreg.sv
// Directed vector bench for pipe_exe_emreg; expectations follow PIPE_EXE_MUL_EN when defined.
module tb_pipe_exe_emreg;

    logic        clock = 1'b0;
    logic        resetn, ebubble, ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
    logic [3:0]  ealuc;
    logic [31:0] ea, eb, eimm, esa, epc4;
    logic [4:0]  ern0, ern, mrn;
    logic        ex_stall, mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;

    int n_checks = 0;
    int n_err    = 0;

`ifdef PIPE_EXE_MUL_EN
    localparam int          STALL_EXP = 33;
    localparam logic [31:0] MUL_EXP   = 32'hFFFFFFEB;
    localparam logic        START_STALL = 1'b1;
`else
    localparam int          STALL_EXP = 0;
    localparam logic [31:0] MUL_EXP   = 32'h00000000;
    localparam logic        START_STALL = 1'b0;
`endif

    pipe_exe_emreg #(.WIDTH(32)) dut (
        .clock(clock), .resetn(resetn), .ebubble(ebubble), .ewreg(ewreg),
        .em2reg(em2reg), .ewmem(ewmem), .ealuc(ealuc), .ealuimm(ealuimm),
        .eshift(eshift), .ejal(ejal), .ea(ea), .eb(eb), .eimm(eimm), .esa(esa),
        .epc4(epc4), .ern0(ern0), .ern(ern), .ex_stall(ex_stall), .mwreg(mwreg),
        .mm2reg(mm2reg), .mwmem(mwmem), .malu(malu), .mb(mb), .mrn(mrn)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        resetn, ebubble, ewreg, em2reg, ewmem;
        logic [3:0]  ealuc;
        logic        ealuimm, eshift, ejal;
        logic [31:0] ea, eb, eimm, esa, epc4;
        logic [4:0]  ern0;
        logic [4:0]  x_ern;
        logic [2:0]  x_ctrl;   // {mwreg, mm2reg, mwmem}
        logic [31:0] x_malu, x_mb;
        logic [4:0]  x_mrn;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic bub, input logic wr,
                                input logic m2r, input logic wm, input logic [3:0] aluc,
                                input logic imm, input logic sh, input logic jal,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] i, input logic [31:0] s,
                                input logic [31:0] pc, input logic [4:0] rn0,
                                input logic [2:0] xctrl, input logic [31:0] xalu);
        vec_t v;
        v.resetn = rst; v.ebubble = bub; v.ewreg = wr; v.em2reg = m2r; v.ewmem = wm;
        v.ealuc = aluc; v.ealuimm = imm; v.eshift = sh; v.ejal = jal;
        v.ea = a; v.eb = b; v.eimm = i; v.esa = s; v.epc4 = pc; v.ern0 = rn0;
        v.x_ern  = jal ? 5'd31 : rn0;
        v.x_ctrl = xctrl;
        v.x_malu = xalu;
        v.x_mb   = rst ? b : 32'd0;
        v.x_mrn  = rst ? v.x_ern : 5'd0;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        resetn = v.resetn; ebubble = v.ebubble; ewreg = v.ewreg; em2reg = v.em2reg;
        ewmem = v.ewmem; ealuc = v.ealuc; ealuimm = v.ealuimm; eshift = v.eshift;
        ejal = v.ejal; ea = v.ea; eb = v.eb; eimm = v.eimm; esa = v.esa;
        epc4 = v.epc4; ern0 = v.ern0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_stall;
        //                 rst bub wr m2r wm aluc   imm sh jal ea            eb            eimm          esa       epc4          rn0    ctrl    malu
        vecs.push_back(mk(0, 1, 1, 1, 1, 4'b0000, 1, 1, 1, 32'h11,       32'h22,       32'h33,       32'h4,    32'h100,      5'd9,  3'b000, 32'h0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 4'b0000, 1, 1, 1, 32'h11,       32'h22,       32'h33,       32'h4,    32'h100,      5'd9,  3'b000, 32'h0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 32'd5,        32'd7,        32'h0,        32'h0,    32'h0,        5'd3,  3'b100, 32'd12));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'b0000, 1, 0, 0, 32'd3,        32'h0,        32'hFFFFFFFC, 32'h0,    32'h0,        5'd4,  3'b100, 32'hFFFFFFFF));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'b1111, 0, 1, 0, 32'h0,        32'h80000000, 32'h0,        32'd4,    32'h0,        5'd5,  3'b100, 32'hF8000000));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'b1111, 0, 1, 0, 32'h0,        32'h7FFFFFF0, 32'h0,        32'd4,    32'h0,        5'd5,  3'b100, 32'h07FFFFFF));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'b0111, 0, 1, 0, 32'h0,        32'h80000000, 32'h0,        32'd4,    32'h0,        5'd6,  3'b100, 32'h08000000));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'b0011, 0, 0, 0, 32'h23,       32'h1,        32'h0,        32'h0,    32'h0,        5'd7,  3'b100, 32'h8));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'b0100, 0, 0, 0, 32'd5,        32'd7,        32'h0,        32'h0,    32'h0,        5'd8,  3'b100, 32'hFFFFFFFE));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'b1001, 0, 0, 0, 32'hF0F0,     32'hFF00,     32'h0,        32'h0,    32'h0,        5'd9,  3'b100, 32'hF000));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'b0101, 0, 0, 0, 32'hF0F0,     32'hFF00,     32'h0,        32'h0,    32'h0,        5'd10, 3'b100, 32'hFFF0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'b1010, 0, 0, 0, 32'hF0F0,     32'hFF00,     32'h0,        32'h0,    32'h0,        5'd11, 3'b100, 32'h0FF0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'b0110, 1, 0, 0, 32'h0,        32'h1234,     32'hABCD,     32'h0,    32'h0,        5'd12, 3'b100, 32'hABCD0000));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'b0000, 0, 0, 1, 32'h1,        32'h2,        32'h0,        32'h0,    32'h104,      5'd0,  3'b100, 32'h108));
        vecs.push_back(mk(1, 1, 1, 1, 1, 4'b0000, 0, 0, 0, 32'h1,        32'h2,        32'h0,        32'h0,    32'h0,        5'd13, 3'b000, 32'h3));
        vecs.push_back(mk(1, 0, 1, 1, 0, 4'b0000, 1, 0, 0, 32'h100,      32'h0,        32'h8,        32'h0,    32'h0,        5'd14, 3'b110, 32'h108));
        vecs.push_back(mk(1, 0, 0, 0, 1, 4'b0000, 1, 0, 0, 32'h200,      32'hDEADBEEF, 32'h4,        32'h0,    32'h0,        5'd15, 3'b001, 32'h204));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 32'hFFFFFFFF, 32'h2,        32'h0,        32'h0,    32'h0,        5'd16, 3'b100, 32'h1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 4'b1011, 0, 0, 0, 32'd7,        32'd3,        32'h0,        32'h0,    32'h0,        5'd17, 3'b000, 32'h0));
`ifndef PIPE_EXE_MUL_EN
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'b1011, 0, 0, 0, 32'd7,        32'd3,        32'h0,        32'h0,    32'h0,        5'd18, 3'b100, 32'h0));
`endif

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d ern", i), {27'd0, ern}, {27'd0, vecs[i].x_ern});
            check($sformatf("v%0d ex_stall", i), {31'd0, ex_stall}, 32'd0);
            @(posedge clock); #1;
            check($sformatf("v%0d ctrl", i), {29'd0, mwreg, mm2reg, mwmem}, {29'd0, vecs[i].x_ctrl});
            check($sformatf("v%0d malu", i), malu, vecs[i].x_malu);
            check($sformatf("v%0d mb", i), mb, vecs[i].x_mb);
            check($sformatf("v%0d mrn", i), {27'd0, mrn}, {27'd0, vecs[i].x_mrn});
        end

        // Known value in malu, then a multiply with inputs held for its whole duration.
        ebubble = 1'b0; ewreg = 1'b1; em2reg = 1'b0; ewmem = 1'b0; ealuimm = 1'b0;
        eshift = 1'b0; ejal = 1'b0; ealuc = 4'b0000; ea = 32'd20; eb = 32'd22; ern0 = 5'd2;
        @(posedge clock); #1;
        check("pre-mul add", malu, 32'd42);
        ealuc = 4'b1011; ea = 32'd7; eb = 32'hFFFFFFFD; ern0 = 5'd10;
        n_stall = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!ex_stall) break;
            n_stall++;
            @(posedge clock); #1;
            check("mul stall mwreg", {31'd0, mwreg}, 32'd0);
            check("mul stall malu hold", malu, 32'd42);
        end
        check("mul stall cycles", n_stall, STALL_EXP);
        @(posedge clock); #1;
        check("mul malu", malu, MUL_EXP);
        check("mul mwreg", {31'd0, mwreg}, 32'd1);
        check("mul mrn", {27'd0, mrn}, 32'd10);
        ealuc = 4'b0000;

        // Reset in the middle of a multiply (count=10 in BUSY).
        ealuc = 4'b1011; ea = 32'd7; eb = 32'd3; ern0 = 5'd11;
        #1;
        check("mid start stall", {31'd0, ex_stall}, {31'd0, START_STALL});
        repeat (11) @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        check("mid rst stall comb", {31'd0, ex_stall}, 32'd0);
        @(posedge clock); #1;
        check("mid rst stall", {31'd0, ex_stall}, 32'd0);
        check("mid rst ctrl", {29'd0, mwreg, mm2reg, mwmem}, 32'd0);
        check("mid rst malu", malu, 32'd0);
        check("mid rst mb", mb, 32'd0);
        check("mid rst mrn", {27'd0, mrn}, 32'd0);
        resetn = 1'b1; ealuc = 4'b0000; ea = 32'd5; eb = 32'd7; ern0 = 5'd4;
        #1;
        check("post rst stall", {31'd0, ex_stall}, 32'd0);
        @(posedge clock); #1;
        check("post rst malu", malu, 32'd12);
        check("post rst mwreg", {31'd0, mwreg}, 32'd1);
        check("post rst mrn", {27'd0, mrn}, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
